hazard_ctrl_fsm: RTL and testbench

- Parametrised hazard/stall controller for the 5-stage MIPS pipeline; sits in ID beside the decoder.
- Covers load-use stalls for all instructions, not only branches.
- With branch-in-ID, also stalls branches on ALU results still in EX.
- Supports multi-cycle loads (LOAD_STALL > 1), freezes the whole pipe while data memory is busy, flushes IF/ID on a taken branch, and keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_fsm.sv | 162 ++++++++++++++++
 tb/tb_hazard_ctrl_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_fsm.sv
// Hazard/stall controller for the 5-stage pipeline, placed in ID beside the decoder.
// Handles load-use and branch-in-ID hazards, memory-busy freeze, branch flush and perf counters.
module hazard_ctrl_fsm #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int BR_IN_ID   = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_branch,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_regwrite,
    input  logic              id_ex_memread,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_memread,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              perf_clr,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              pipe_en,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, MEM_WAIT = 2'd2} state_t;
    typedef enum logic [1:0] {M_RUN = 2'd0, M_STALL = 2'd1, M_FREEZE = 2'd2} mode_t;

    // A branch waiting on a load in EX needs LOAD_STALL+1 (up to 8) bubbles, so depth is
    // one bit wider than rem; rem = d-1 always fits in 3 bits.
    localparam logic [3:0] LS  = 4'(LOAD_STALL);
    localparam logic [3:0] LS1 = 4'(LOAD_STALL + 1);

    state_t     state_reg, state_next, act_state;
    logic [2:0] rem_reg, rem_next;
    logic       ret_reg, ret_next;
    mode_t      mode;
    logic       m_ex, m_mem;
    logic [3:0] d, d_load_ex, d_alu_ex, d_load_mem;

    assign m_ex  = (id_ex_rd != '0) &&
                   ((id_uses_rs && (id_rs == id_ex_rd)) || (id_uses_rt && (id_rt == id_ex_rd)));
    assign m_mem = (ex_mem_rd != '0) &&
                   ((id_uses_rs && (id_rs == ex_mem_rd)) || (id_uses_rt && (id_rt == ex_mem_rd)));

    always_comb begin
        d_load_ex  = '0;
        d_alu_ex   = '0;
        d_load_mem = '0;
        if ((BR_IN_ID != 0) && id_is_branch) begin
            if (id_ex_memread && m_ex)                    d_load_ex  = LS1;
            if (id_ex_regwrite && !id_ex_memread && m_ex) d_alu_ex   = 4'd1;
            if (ex_mem_memread && m_mem)                  d_load_mem = LS;
        end else if (id_ex_memread && m_ex) begin
            d_load_ex = LS;
        end
        d = d_load_ex;
        if (d_alu_ex > d)   d = d_alu_ex;
        if (d_load_mem > d) d = d_load_mem;
    end

    // Leaving MEM_WAIT behaves as the return state within the same cycle.
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        ret_next   = ret_reg;
        mode       = M_RUN;
        act_state  = state_reg;
        if ((state_reg == MEM_WAIT) && !mem_busy) begin
            act_state = ret_reg ? STALL : IDLE;
        end
        case (act_state)
            IDLE: begin
                if (mem_busy) begin
                    mode       = M_FREEZE;
                    ret_next   = 1'b0;
                    state_next = MEM_WAIT;
                end else if (d != 4'd0) begin
                    mode       = M_STALL;
                    state_next = IDLE;
                    if (d > 4'd1) begin
                        rem_next   = 3'(d - 4'd1);
                        state_next = STALL;
                    end
                end else begin
                    mode       = M_RUN;
                    state_next = IDLE;
                end
            end
            STALL: begin
                if (mem_busy) begin
                    mode       = M_FREEZE;
                    ret_next   = 1'b1;
                    state_next = MEM_WAIT;
                end else begin
                    mode       = M_STALL;
                    rem_next   = rem_reg - 3'd1;
                    state_next = (rem_reg == 3'd1) ? IDLE : STALL;
                end
            end
            default: begin
                mode       = M_FREEZE;
                state_next = MEM_WAIT;
            end
        endcase
    end

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        pipe_en     = 1'b0;
        id_ex_flush = 1'b0;
        if_id_flush = 1'b0;
        if (rst_n) begin
            case (mode)
                M_RUN: begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    pipe_en     = 1'b1;
                    if_id_flush = branch_taken;
                end
                M_STALL: begin
                    pipe_en     = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            ret_reg   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            ret_reg   <= ret_next;
            if (perf_clr) begin
                stall_cnt <= '0;
            end else if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (perf_clr) begin
                flush_cnt <= '0;
            end else if (if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_fsm.sv
// Directed bench for hazard_ctrl_fsm: three parameterisations share one stimulus bus,
// each section checks the instance whose parameters it targets.
module tb_hazard_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, perf_clr;
    logic [4:0] id_rs, id_rt, id_ex_rd, ex_mem_rd;
    logic       id_uses_rs, id_uses_rt, id_is_branch, id_ex_regwrite, id_ex_memread;
    logic       ex_mem_memread, branch_taken, mem_busy;

    logic        pc_en_a, if_id_en_a, if_id_flush_a, id_ex_flush_a, pipe_en_a;
    logic        pc_en_b, if_id_en_b, if_id_flush_b, id_ex_flush_b, pipe_en_b;
    logic        pc_en_c, if_id_en_c, if_id_flush_c, id_ex_flush_c, pipe_en_c;
    logic [15:0] stall_cnt_a, flush_cnt_a, stall_cnt_c, flush_cnt_c;
    logic [3:0]  stall_cnt_b, flush_cnt_b;

    // a: LOAD_STALL=1 branch-in-ID; b: LOAD_STALL=2 with 4-bit counters; c: branches as plain consumers
    hazard_ctrl_fsm #(.REG_AW(5), .LOAD_STALL(1), .BR_IN_ID(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch), .id_ex_rd(id_ex_rd),
        .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd),
        .ex_mem_memread(ex_mem_memread), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .perf_clr(perf_clr), .pc_en(pc_en_a), .if_id_en(if_id_en_a), .if_id_flush(if_id_flush_a),
        .id_ex_flush(id_ex_flush_a), .pipe_en(pipe_en_a), .stall_cnt(stall_cnt_a),
        .flush_cnt(flush_cnt_a));

    hazard_ctrl_fsm #(.REG_AW(5), .LOAD_STALL(2), .BR_IN_ID(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch), .id_ex_rd(id_ex_rd),
        .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd),
        .ex_mem_memread(ex_mem_memread), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .perf_clr(perf_clr), .pc_en(pc_en_b), .if_id_en(if_id_en_b), .if_id_flush(if_id_flush_b),
        .id_ex_flush(id_ex_flush_b), .pipe_en(pipe_en_b), .stall_cnt(stall_cnt_b),
        .flush_cnt(flush_cnt_b));

    hazard_ctrl_fsm #(.REG_AW(5), .LOAD_STALL(1), .BR_IN_ID(0), .CNT_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch), .id_ex_rd(id_ex_rd),
        .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd),
        .ex_mem_memread(ex_mem_memread), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .perf_clr(perf_clr), .pc_en(pc_en_c), .if_id_en(if_id_en_c), .if_id_flush(if_id_flush_c),
        .id_ex_flush(id_ex_flush_c), .pipe_en(pipe_en_c), .stall_cnt(stall_cnt_c),
        .flush_cnt(flush_cnt_c));

    // Observed encoding {pc_en, id_ex_flush, pipe_en, if_id_flush}; if_id_en must track pc_en.
    localparam logic [3:0] RUN  = 4'b1010;
    localparam logic [3:0] RUNF = 4'b1011;
    localparam logic [3:0] STL  = 4'b0110;
    localparam logic [3:0] FRZ  = 4'b0000;

    int n_cmp = 0;
    int n_bad = 0;

    // flags = {uses_rs, uses_rt, is_branch, ex_regwrite, ex_memread, mem_memread, taken, busy}
    typedef struct {
        logic [4:0] rs, rt, exrd, memrd;
        logic [7:0] flags;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(int rs, int rt, int exrd, int memrd, logic [7:0] f, logic [3:0] e);
        vec_t v;
        v.rs    = rs[4:0];
        v.rt    = rt[4:0];
        v.exrd  = exrd[4:0];
        v.memrd = memrd[4:0];
        v.flags = f;
        v.exp   = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, compare the selected instance mid-cycle, return just after the edge.
    task automatic cyc(input int rs, input int rt, input int exrd, input int memrd,
                       input logic [7:0] f, input int sel, input logic [3:0] exp, input string name);
        logic [3:0] obs;
        logic       en_ok;
        id_rs     = rs[4:0];
        id_rt     = rt[4:0];
        id_ex_rd  = exrd[4:0];
        ex_mem_rd = memrd[4:0];
        {id_uses_rs, id_uses_rt, id_is_branch, id_ex_regwrite, id_ex_memread,
         ex_mem_memread, branch_taken, mem_busy} = f;
        @(negedge clk);
        case (sel)
            0:       begin obs = {pc_en_a, id_ex_flush_a, pipe_en_a, if_id_flush_a}; en_ok = (if_id_en_a == pc_en_a); end
            1:       begin obs = {pc_en_b, id_ex_flush_b, pipe_en_b, if_id_flush_b}; en_ok = (if_id_en_b == pc_en_b); end
            default: begin obs = {pc_en_c, id_ex_flush_c, pipe_en_c, if_id_flush_c}; en_ok = (if_id_en_c == pc_en_c); end
        endcase
        $display("[%0t] %s dut%0d out=%b exp=%b", $time, name, sel, obs, exp);
        check(name, 16'(obs), 16'(exp));
        check({name, "_ifid_en"}, 16'(en_ok), 16'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int sel);
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 8'b0010_0010, sel, FRZ, "in_reset");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        perf_clr = 1'b0;
        id_rs = '0; id_rt = '0; id_ex_rd = '0; ex_mem_rd = '0;
        {id_uses_rs, id_uses_rt, id_is_branch, id_ex_regwrite, id_ex_memread,
         ex_mem_memread, branch_taken, mem_busy} = 8'b0;

        vecs[0]  = mk(0, 0, 0, 0, 8'b0000_0000, RUN);   // nothing in flight
        vecs[1]  = mk(3, 0, 3, 0, 8'b1001_1000, STL);   // add r3 after lw r3
        vecs[2]  = mk(3, 0, 0, 0, 8'b1000_0000, RUN);   // bubble now in EX
        vecs[3]  = mk(0, 0, 0, 0, 8'b1001_1000, RUN);   // lw r0 never hazards
        vecs[4]  = mk(1, 5, 5, 0, 8'b1001_1000, RUN);   // rt matches but unused
        vecs[5]  = mk(4, 0, 4, 0, 8'b1001_0000, RUN);   // ALU result is forwardable
        vecs[6]  = mk(3, 0, 0, 3, 8'b1000_0100, RUN);   // load in MEM, non-branch
        vecs[7]  = mk(0, 0, 0, 0, 8'b0010_0010, RUNF);  // taken branch flushes
        vecs[8]  = mk(4, 0, 4, 0, 8'b1011_0010, STL);   // beq on add in EX
        vecs[9]  = mk(0, 3, 0, 3, 8'b0110_0100, STL);   // beq rt on load in MEM
        vecs[10] = mk(3, 0, 3, 0, 8'b1011_1010, STL);   // beq on lw in EX: d=2
        vecs[11] = mk(0, 0, 0, 0, 8'b0010_0010, STL);   // STALL ignores inputs
        vecs[12] = mk(0, 0, 0, 0, 8'b0010_0010, RUNF);
        vecs[13] = mk(3, 0, 3, 0, 8'b1001_1011, FRZ);   // busy beats hazard and flush
        vecs[14] = mk(3, 0, 3, 0, 8'b1001_1011, FRZ);
        vecs[15] = mk(3, 0, 3, 0, 8'b1001_1010, STL);   // resume re-evaluates hazard
        vecs[16] = mk(0, 0, 0, 0, 8'b0000_0000, RUN);

        do_reset(0);
        check("a_rst_stall_cnt", stall_cnt_a, 16'd0);
        check("a_rst_flush_cnt", flush_cnt_a, 16'd0);
        for (int i = 0; i < 17; i++) begin
            cyc(int'(vecs[i].rs), int'(vecs[i].rt), int'(vecs[i].exrd), int'(vecs[i].memrd),
                vecs[i].flags, 0, vecs[i].exp, $sformatf("a_vec%0d", i));
        end
        check("a_stall_cnt", stall_cnt_a, 16'd8);
        check("a_flush_cnt", flush_cnt_a, 16'd2);

        // LOAD_STALL=2: branch on lw in EX takes three stall cycles, no flush while stalled
        do_reset(1);
        for (int i = 0; i < 3; i++) cyc(3, 0, 3, 0, 8'b1011_1010, 1, STL, $sformatf("b_br_lw%0d", i));
        cyc(0, 0, 0, 0, 8'b0000_0000, 1, RUN, "b_br_lw_done");
        check("b_stall_cnt3", 16'(stall_cnt_b), 16'd3);

        // Freeze inside STALL with rem=1 holds rem, then one stall cycle finishes it
        cyc(3, 0, 3, 0, 8'b1001_1000, 1, STL, "b_lw_enter");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'b0000_0001, 1, FRZ, $sformatf("b_frz%0d", i));
        cyc(0, 0, 0, 0, 8'b0000_0000, 1, STL, "b_resume");
        cyc(0, 0, 0, 0, 8'b0000_0000, 1, RUN, "b_after");
        check("b_stall_cnt8", 16'(stall_cnt_b), 16'd8);

        // 4-bit counter saturates, then perf_clr wins over a counting cycle
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 8'b0000_0001, 1, FRZ, $sformatf("b_fill%0d", i));
        check("b_sat15", 16'(stall_cnt_b), 16'd15);
        cyc(0, 0, 0, 0, 8'b0000_0001, 1, FRZ, "b_sat_hold");
        check("b_sat_hold", 16'(stall_cnt_b), 16'd15);
        perf_clr = 1'b1;
        cyc(0, 0, 0, 0, 8'b0000_0001, 1, FRZ, "b_clr");
        perf_clr = 1'b0;
        check("b_clr_cnt", 16'(stall_cnt_b), 16'd0);
        cyc(0, 0, 0, 0, 8'b0000_0000, 1, RUN, "b_clr_run");
        check("b_clr_run_cnt", 16'(stall_cnt_b), 16'd0);

        // Reset in the middle of STALL aborts it
        cyc(3, 0, 3, 0, 8'b1001_1000, 1, STL, "b_pre_rst");
        rst_n = 1'b0;
        cyc(3, 0, 3, 0, 8'b1001_1010, 1, FRZ, "b_in_rst");
        rst_n = 1'b1;
        check("b_rst_cnt", 16'(stall_cnt_b), 16'd0);
        cyc(0, 0, 0, 0, 8'b0000_0000, 1, RUN, "b_post_rst");
        check("b_post_rst_cnt", 16'(stall_cnt_b), 16'd0);
        check("b_post_rst_fcnt", 16'(flush_cnt_b), 16'd0);

        // Without branch-in-ID a beq on an ALU result runs; only load-use stalls it
        do_reset(2);
        cyc(4, 0, 4, 0, 8'b1011_0010, 2, RUNF, "c_br_alu");
        cyc(3, 0, 3, 0, 8'b1011_1000, 2, STL, "c_br_lw");
        cyc(0, 0, 0, 0, 8'b0000_0000, 2, RUN, "c_after");
        check("c_stall_cnt", stall_cnt_c, 16'd1);
        check("c_flush_cnt", flush_cnt_c, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
